// File: rtl/hazard_bypass_unit_if.sv
// Signal bundle between the KLP32 decode/execute pipeline and the hazard/bypass unit.
// Every signal is level-qualified each cycle. There is no valid/ready handshake:
// the pipeline drives its stage fields and enables, and the unit answers in the same cycle.
interface hazard_bypass_unit_if #(
    parameter int AW       = 5,
    parameter int NREG     = 2**AW,
    parameter int MAX_PEND = 4
);
    localparam int CW = $clog2(MAX_PEND + 1);

    logic [AW-1:0]   ID_RS1, ID_RS2, ID_RD;
    logic            ID_USE_RS1, ID_USE_RS2, ID_IS_LONG;
    logic [AW-1:0]   IX_RS1, IX_RS2, IX_RD;
    logic            IX_WE, IX_IS_LOAD, IX_IS_LONG;
    logic [AW-1:0]   IM_RS2, IM_RD;
    logic            IM_WE;
    logic [AW-1:0]   IW_RD;
    logic            IW_WE;
    logic            LONG_DONE;
    logic [AW-1:0]   LONG_RD;

    logic [1:0]      a_sel_mux, b_sel_mux;
    logic            data_sel_mux;
    logic            stall_fd, bubble_x;
    logic [NREG-1:0] sb_pending;
    logic            sb_full, sb_err;
    logic [CW-1:0]   sb_count;

    modport slave (
        input  ID_RS1, ID_RS2, ID_RD, ID_USE_RS1, ID_USE_RS2, ID_IS_LONG,
        input  IX_RS1, IX_RS2, IX_RD, IX_WE, IX_IS_LOAD, IX_IS_LONG,
        input  IM_RS2, IM_RD, IM_WE, IW_RD, IW_WE, LONG_DONE, LONG_RD,
        output a_sel_mux, b_sel_mux, data_sel_mux, stall_fd, bubble_x,
        output sb_pending, sb_full, sb_err, sb_count
    );

    modport master (
        output ID_RS1, ID_RS2, ID_RD, ID_USE_RS1, ID_USE_RS2, ID_IS_LONG,
        output IX_RS1, IX_RS2, IX_RD, IX_WE, IX_IS_LOAD, IX_IS_LONG,
        output IM_RS2, IM_RD, IM_WE, IW_RD, IW_WE, LONG_DONE, LONG_RD,
        input  a_sel_mux, b_sel_mux, data_sel_mux, stall_fd, bubble_x,
        input  sb_pending, sb_full, sb_err, sb_count
    );
endinterface

// File: rtl/hazard_bypass_unit.sv
// KLP32 forwarding and hazard control: operand/store bypass selects, load-use and
// long-latency stalls, and a registered scoreboard of outstanding long writes.
module hazard_bypass_unit #(
    parameter int AW       = 5,
    parameter int NREG     = 2**AW,
    parameter int MAX_PEND = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_bypass_unit_if.slave  hb
);
    localparam int CW = $clog2(MAX_PEND + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_PEND);
    localparam logic [CW-1:0] NEAR_CNT = CW'(MAX_PEND - 1);
    localparam logic [AW-1:0] X0       = '0;

    logic [NREG-1:0] pending_q;
    logic [CW-1:0]   count_q;
    logic            err_q;

    logic m_fwd_ok, w_fwd_ok, x_long_wr;
    logic set_req, set_ok, clr_ok, clr_bad;
    logic load_use, long_raw, long_waw, full_now;

    assign m_fwd_ok  = hb.IM_WE && (hb.IM_RD != X0);
    assign w_fwd_ok  = hb.IW_WE && (hb.IW_RD != X0);
    assign x_long_wr = hb.IX_IS_LONG && hb.IX_WE;
    assign full_now  = (count_q == FULL_CNT);

    // M-stage result is newer than W-stage, so it wins when both match.
    always_comb begin
        hb.a_sel_mux = 2'b00;
        if (m_fwd_ok && hb.IX_RS1 == hb.IM_RD)      hb.a_sel_mux = 2'b01;
        else if (w_fwd_ok && hb.IX_RS1 == hb.IW_RD) hb.a_sel_mux = 2'b10;

        hb.b_sel_mux = 2'b00;
        if (m_fwd_ok && hb.IX_RS2 == hb.IM_RD)      hb.b_sel_mux = 2'b01;
        else if (w_fwd_ok && hb.IX_RS2 == hb.IW_RD) hb.b_sel_mux = 2'b10;
    end

    assign hb.data_sel_mux = w_fwd_ok && (hb.IM_RS2 == hb.IW_RD);

    assign load_use = hb.IX_IS_LOAD && hb.IX_WE && (hb.IX_RD != X0) &&
                      ((hb.ID_USE_RS1 && hb.ID_RS1 == hb.IX_RD) ||
                       (hb.ID_USE_RS2 && hb.ID_RS2 == hb.IX_RD));

    // The IX compare covers the cycle before an issue shows up in pending_q.
    assign long_raw =
        (hb.ID_USE_RS1 && hb.ID_RS1 != X0 &&
         (pending_q[hb.ID_RS1] || (x_long_wr && hb.ID_RS1 == hb.IX_RD))) ||
        (hb.ID_USE_RS2 && hb.ID_RS2 != X0 &&
         (pending_q[hb.ID_RS2] || (x_long_wr && hb.ID_RS2 == hb.IX_RD)));

    assign long_waw = hb.ID_IS_LONG && (hb.ID_RD != X0) &&
                      (pending_q[hb.ID_RD] ||
                       (x_long_wr && hb.ID_RD == hb.IX_RD) ||
                       full_now ||
                       (count_q == NEAR_CNT && set_req));

    assign hb.stall_fd = load_use || long_raw || long_waw;
    assign hb.bubble_x = hb.stall_fd;

    assign set_req = x_long_wr && (hb.IX_RD != X0);
    assign clr_ok  = hb.LONG_DONE && (hb.LONG_RD != X0) && pending_q[hb.LONG_RD];
    assign clr_bad = hb.LONG_DONE && !clr_ok;
    // Saturation guard: a set with no room and no matching clear is dropped.
    assign set_ok  = set_req && (!full_now || clr_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (clr_ok) pending_q[hb.LONG_RD] <= 1'b0;
            if (set_ok) pending_q[hb.IX_RD]   <= 1'b1;
            if (set_ok && !clr_ok)      count_q <= count_q + 1'b1;
            else if (clr_ok && !set_ok) count_q <= count_q - 1'b1;
            if (clr_bad) err_q <= 1'b1;
        end
    end

    assign hb.sb_pending = pending_q;
    assign hb.sb_full    = full_now;
    assign hb.sb_err     = err_q;
    assign hb.sb_count   = count_q;
endmodule

// File: tb/tb_hazard_bypass_unit.sv
// Directed bench for hazard_bypass_unit: the driver pushes hand-computed expectations,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_bypass_unit;
    localparam int AW = 5;
    localparam int NREG = 32;
    localparam int MAX_PEND = 4;
    localparam int W = 2 + 2 + 1 + 1 + 1 + 1 + 1 + 3 + NREG;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [W-1:0] exp_q[$];
    string        name_q[$];

    hazard_bypass_unit_if #(.AW(AW), .NREG(NREG), .MAX_PEND(MAX_PEND)) hb ();

    hazard_bypass_unit #(.AW(AW), .NREG(NREG), .MAX_PEND(MAX_PEND)) dut (
        .clk   (clk),
        .reset (reset),
        .hb    (hb.slave)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks
    task automatic idle_inputs();
        hb.ID_RS1 = '0; hb.ID_RS2 = '0; hb.ID_RD = '0;
        hb.ID_USE_RS1 = 1'b0; hb.ID_USE_RS2 = 1'b0; hb.ID_IS_LONG = 1'b0;
        hb.IX_RS1 = '0; hb.IX_RS2 = '0; hb.IX_RD = '0;
        hb.IX_WE = 1'b0; hb.IX_IS_LOAD = 1'b0; hb.IX_IS_LONG = 1'b0;
        hb.IM_RS2 = '0; hb.IM_RD = '0; hb.IM_WE = 1'b0;
        hb.IW_RD = '0; hb.IW_WE = 1'b0;
        hb.LONG_DONE = 1'b0; hb.LONG_RD = '0;
    endtask

    task automatic long_issue(input logic [AW-1:0] rd);
        hb.IX_IS_LONG = 1'b1; hb.IX_WE = 1'b1; hb.IX_RD = rd;
    endtask

    // Queue the expectation for the inputs now applied, then advance one cycle.
    task automatic expect_step(input string nm, input logic [1:0] a, input logic [1:0] b,
                               input logic d, input logic st, input logic full,
                               input logic err, input logic [2:0] cnt,
                               input logic [NREG-1:0] pend);
        exp_q.push_back({a, b, d, st, st, full, err, cnt, pend});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e, g;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            g = {hb.a_sel_mux, hb.b_sel_mux, hb.data_sel_mux, hb.stall_fd, hb.bubble_x,
                 hb.sb_full, hb.sb_err, hb.sb_count, hb.sb_pending};
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL %s: got a=%b b=%b d=%b stall=%b bub=%b full=%b err=%b cnt=%0d pend=%h, expected a=%b b=%b d=%b stall=%b bub=%b full=%b err=%b cnt=%0d pend=%h",
                         nm, g[W-1-:2], g[W-3-:2], g[W-5], g[W-6], g[W-7], g[W-8], g[W-9],
                         g[NREG+2-:3], g[NREG-1:0],
                         e[W-1-:2], e[W-3-:2], e[W-5], e[W-6], e[W-7], e[W-8], e[W-9],
                         e[NREG+2-:3], e[NREG-1:0]);
            end
        end
    end

    initial begin
        idle_inputs();
        @(posedge clk); #1;
        expect_step("reset_state", 2'b00, 2'b00, 0, 0, 0, 0, 3'd0, 32'h0);
        reset = 1'b0;

        // forwarding priority and x0 exclusion
        idle_inputs();
        hb.IX_RS1 = 5'd4; hb.IM_RD = 5'd4; hb.IM_WE = 1; hb.IW_RD = 5'd4; hb.IW_WE = 1;
        expect_step("fwd_a_m_prio", 2'b01, 2'b00, 0, 0, 0, 0, 3'd0, 32'h0);
        hb.IM_WE = 0;
        expect_step("fwd_a_w", 2'b10, 2'b00, 0, 0, 0, 0, 3'd0, 32'h0);
        hb.IM_WE = 1; hb.IM_RD = '0; hb.IW_RD = '0; hb.IX_RS1 = '0;
        expect_step("fwd_a_x0", 2'b00, 2'b00, 0, 0, 0, 0, 3'd0, 32'h0);
        idle_inputs();
        hb.IX_RS2 = 5'd6; hb.IW_RD = 5'd6; hb.IW_WE = 1; hb.IM_RD = 5'd6;
        expect_step("fwd_b_w_m_off", 2'b00, 2'b10, 0, 0, 0, 0, 3'd0, 32'h0);
        idle_inputs();
        hb.IM_RS2 = 5'd5; hb.IW_RD = 5'd5; hb.IW_WE = 1;
        expect_step("store_fwd_on", 2'b00, 2'b00, 1, 0, 0, 0, 3'd0, 32'h0);
        hb.IW_WE = 0;
        expect_step("store_fwd_off", 2'b00, 2'b00, 0, 0, 0, 0, 3'd0, 32'h0);

        // load-use
        idle_inputs();
        hb.IX_IS_LOAD = 1; hb.IX_WE = 1; hb.IX_RD = 5'd7; hb.ID_RS2 = 5'd7; hb.ID_USE_RS2 = 1;
        expect_step("load_use_stall", 2'b00, 2'b00, 0, 1, 0, 0, 3'd0, 32'h0);
        idle_inputs();
        hb.IM_RD = 5'd7; hb.IM_WE = 1; hb.IX_RS2 = 5'd7;
        expect_step("load_use_after", 2'b00, 2'b01, 0, 0, 0, 0, 3'd0, 32'h0);
        idle_inputs();
        hb.IX_IS_LOAD = 1; hb.IX_WE = 1; hb.IX_RD = 5'd7; hb.ID_RS2 = 5'd7;
        expect_step("load_unused_src", 2'b00, 2'b00, 0, 0, 0, 0, 3'd0, 32'h0);
        hb.IX_RD = '0; hb.ID_RS1 = '0; hb.ID_USE_RS1 = 1;
        expect_step("load_x0_nostall", 2'b00, 2'b00, 0, 0, 0, 0, 3'd0, 32'h0);

        // long RAW on x9
        idle_inputs();
        long_issue(5'd9); hb.ID_RS1 = 5'd9; hb.ID_USE_RS1 = 1;
        expect_step("long_raw_issue", 2'b00, 2'b00, 0, 1, 0, 0, 3'd0, 32'h0);
        idle_inputs();
        hb.ID_RS1 = 5'd9; hb.ID_USE_RS1 = 1;
        expect_step("long_raw_pending", 2'b00, 2'b00, 0, 1, 0, 0, 3'd1, 32'h200);
        hb.LONG_DONE = 1; hb.LONG_RD = 5'd9;
        expect_step("long_raw_done_cyc", 2'b00, 2'b00, 0, 1, 0, 0, 3'd1, 32'h200);
        hb.LONG_DONE = 0; hb.LONG_RD = '0;
        expect_step("long_raw_released", 2'b00, 2'b00, 0, 0, 0, 0, 3'd0, 32'h0);

        // fill to MAX_PEND
        idle_inputs(); long_issue(5'd1);
        expect_step("fill_x1", 2'b00, 2'b00, 0, 0, 0, 0, 3'd0, 32'h0);
        long_issue(5'd2);
        expect_step("fill_x2", 2'b00, 2'b00, 0, 0, 0, 0, 3'd1, 32'h2);
        long_issue(5'd3);
        expect_step("fill_x3", 2'b00, 2'b00, 0, 0, 0, 0, 3'd2, 32'h6);
        long_issue(5'd4); hb.ID_IS_LONG = 1; hb.ID_RD = 5'd6;
        expect_step("near_full_struct", 2'b00, 2'b00, 0, 1, 0, 0, 3'd3, 32'he);
        idle_inputs(); hb.ID_IS_LONG = 1; hb.ID_RD = 5'd5;
        expect_step("full_struct", 2'b00, 2'b00, 0, 1, 1, 0, 3'd4, 32'h1e);
        idle_inputs(); hb.ID_RS2 = 5'd3; hb.ID_USE_RS2 = 1;
        expect_step("raw_pending_x3", 2'b00, 2'b00, 0, 1, 1, 0, 3'd4, 32'h1e);
        idle_inputs(); hb.LONG_DONE = 1; hb.LONG_RD = 5'd2; long_issue(5'd5);
        expect_step("set_clr_same", 2'b00, 2'b00, 0, 0, 1, 0, 3'd4, 32'h1e);
        idle_inputs(); hb.LONG_DONE = 1; hb.LONG_RD = 5'd1;
        expect_step("count_held", 2'b00, 2'b00, 0, 0, 1, 0, 3'd4, 32'h3a);
        idle_inputs(); hb.ID_IS_LONG = 1; hb.ID_RD = 5'd4;
        expect_step("waw_pending", 2'b00, 2'b00, 0, 1, 0, 0, 3'd3, 32'h38);
        hb.ID_RD = 5'd7;
        expect_step("long_free_rd", 2'b00, 2'b00, 0, 0, 0, 0, 3'd3, 32'h38);

        // spurious completion
        idle_inputs(); hb.LONG_DONE = 1; hb.LONG_RD = 5'd12;
        expect_step("err_before", 2'b00, 2'b00, 0, 0, 0, 0, 3'd3, 32'h38);
        idle_inputs();
        expect_step("err_set", 2'b00, 2'b00, 0, 0, 0, 1, 3'd3, 32'h38);
        long_issue(5'd0); hb.ID_RS1 = '0; hb.ID_USE_RS1 = 1; hb.ID_IS_LONG = 1; hb.ID_RD = '0;
        expect_step("x0_long_nostall", 2'b00, 2'b00, 0, 0, 0, 1, 3'd3, 32'h38);
        idle_inputs();
        expect_step("err_sticky", 2'b00, 2'b00, 0, 0, 0, 1, 3'd3, 32'h38);

        // reset mid-operation with a completion in the reset cycle
        reset = 1'b1; hb.LONG_DONE = 1; hb.LONG_RD = 5'd3;
        expect_step("reset_cycle", 2'b00, 2'b00, 0, 0, 0, 1, 3'd3, 32'h38);
        reset = 1'b0; idle_inputs();
        expect_step("after_reset", 2'b00, 2'b00, 0, 0, 0, 0, 3'd0, 32'h0);
        expect_step("after_reset_idle", 2'b00, 2'b00, 0, 0, 0, 0, 3'd0, 32'h0);

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
